// File: rtl/pkt_receiver_gen.sv
// TCP RX front end: filters notifications, issues read-package requests and
// streams payload beats tagged with their session metadata plus SOP/error flags.

module pkt_receiver_gen_fifo #(
   parameter int unsigned W  = 8,
   parameter int unsigned AB = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data_c,
   output logic         full_c,
   output logic         empty_c
);
   localparam int unsigned DEPTH = 1 << AB;

   logic [W-1:0]  mem [DEPTH];
   logic [AB-1:0] wr_ptr;
   logic [AB-1:0] rd_ptr;
   logic [AB:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full_c    = count[AB];
   assign empty_c   = (count == '0);
   assign rd_data_c = mem[rd_ptr];
   assign do_wr     = wr_en && !full_c;
   assign do_rd     = rd_en && !empty_c;

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AB'(1);
         if (do_rd) rd_ptr <= rd_ptr + AB'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AB+1)'(1);
            2'b01:   count <= count - (AB+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module pkt_receiver_gen #(
   parameter int unsigned DATA_WIDTH     = 512,
   parameter int unsigned FIFO_ADDR_BITS = 5,
   parameter int unsigned MAX_LEN        = 4096,
   parameter int unsigned LEN_ALIGN_LOG2 = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [87:0]                s_axis_notifications_TDATA,
   input  logic                       s_axis_notifications_TVALID,
   output logic                       s_axis_notifications_TREADY,
   input  logic [DATA_WIDTH:0]        s_axis_rx_data_TDATA,
   input  logic                       s_axis_rx_data_TVALID,
   output logic                       s_axis_rx_data_TREADY,
   output logic [31:0]                m_axis_read_package_TDATA,
   output logic                       m_axis_read_package_TVALID,
   input  logic                       m_axis_read_package_TREADY,
   output logic [DATA_WIDTH+88:0]     pkt_tx_TDATA,
   output logic                       pkt_tx_TSOP,
   output logic                       pkt_tx_TERR,
   output logic                       pkt_tx_TVALID,
   input  logic                       pkt_tx_TREADY,
   output logic [31:0]                stat_drop_count,
   output logic [31:0]                stat_pkt_count,
   output logic [15:0]                stat_len_err_count
);
   localparam int unsigned NOTIF_W = 88;
   localparam int unsigned BEAT_W  = DATA_WIDTH + 1;
   localparam int unsigned BYTES   = DATA_WIDTH / 8;
   localparam int unsigned CNT_W   = 16;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t state;
   state_t state_nxt;

   logic [NOTIF_W-1:0] notif_head;
   logic               notif_full;
   logic               notif_empty;
   logic               notif_pop;
   logic [NOTIF_W-1:0] meta_head;
   logic               meta_full;
   logic               meta_empty;
   logic               meta_pop;
   logic [BEAT_W-1:0]  pay_head;
   logic               pay_full;
   logic               pay_empty;
   logic               pay_pop;

   logic [15:0]        notif_len;
   logic               accept;
   logic               rp_fire;
   logic               drop;

   logic [NOTIF_W-1:0] meta_r;
   logic [CNT_W-1:0]   exp_beats;
   logic [CNT_W-1:0]   beat_cnt;
   logic [CNT_W-1:0]   exp_calc;
   logic               out_free;
   logic               pay_tlast;
   logic               beat_err;
   logic               tx_last_fire;

   pkt_receiver_gen_fifo #(.W(NOTIF_W), .AB(FIFO_ADDR_BITS)) u_notif_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (s_axis_notifications_TVALID),
      .wr_data   (s_axis_notifications_TDATA),
      .rd_en     (notif_pop),
      .rd_data_c (notif_head),
      .full_c    (notif_full),
      .empty_c   (notif_empty)
   );

   pkt_receiver_gen_fifo #(.W(NOTIF_W), .AB(FIFO_ADDR_BITS)) u_meta_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (rp_fire),
      .wr_data   (notif_head),
      .rd_en     (meta_pop),
      .rd_data_c (meta_head),
      .full_c    (meta_full),
      .empty_c   (meta_empty)
   );

   pkt_receiver_gen_fifo #(.W(BEAT_W), .AB(FIFO_ADDR_BITS)) u_pay_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (s_axis_rx_data_TVALID),
      .wr_data   (s_axis_rx_data_TDATA),
      .rd_en     (pay_pop),
      .rd_data_c (pay_head),
      .full_c    (pay_full),
      .empty_c   (pay_empty)
   );

   assign s_axis_notifications_TREADY = !notif_full;
   assign s_axis_rx_data_TREADY       = !pay_full;

   // Length rule on the notification head; rejects retire in a single cycle.
   assign notif_len = notif_head[31:16];
   assign accept    = (notif_len != 16'd0)
                   && (32'(notif_len) <= 32'(MAX_LEN))
                   && ((notif_len & 16'((32'd1 << LEN_ALIGN_LOG2) - 32'd1)) == 16'd0);

   assign m_axis_read_package_TVALID = !notif_empty && accept && !meta_full;
   assign m_axis_read_package_TDATA  = notif_head[31:0];
   assign rp_fire   = m_axis_read_package_TVALID && m_axis_read_package_TREADY;
   assign drop      = !notif_empty && !accept;
   assign notif_pop = rp_fire || drop;

   assign exp_calc  = CNT_W'((32'(meta_head[31:16]) + 32'(BYTES - 1)) / 32'(BYTES));
   assign out_free  = !pkt_tx_TVALID || pkt_tx_TREADY;
   assign pay_tlast = pay_head[DATA_WIDTH];
   assign beat_err  = (beat_cnt >= exp_beats)
                   || (pay_tlast && ((17'(beat_cnt) + 17'd1) != 17'(exp_beats)));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      meta_pop  = 1'b0;
      pay_pop   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!meta_empty) begin
               meta_pop  = 1'b1;
               state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (!pay_empty && out_free) begin
               pay_pop = 1'b1;
               if (pay_tlast) state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Packet context and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r        <= '0;
         exp_beats     <= '0;
         beat_cnt      <= '0;
         pkt_tx_TVALID <= 1'b0;
         pkt_tx_TDATA  <= '0;
         pkt_tx_TSOP   <= 1'b0;
         pkt_tx_TERR   <= 1'b0;
      end else begin
         if (meta_pop) begin
            meta_r    <= meta_head;
            exp_beats <= exp_calc;
            beat_cnt  <= '0;
         end else if (pay_pop && (beat_cnt != '1)) begin
            beat_cnt  <= beat_cnt + CNT_W'(1);
         end

         if (pay_pop) begin
            pkt_tx_TVALID <= 1'b1;
            pkt_tx_TDATA  <= {meta_r, pay_head};
            pkt_tx_TSOP   <= (beat_cnt == '0);
            pkt_tx_TERR   <= beat_err;
         end else if (pkt_tx_TREADY) begin
            pkt_tx_TVALID <= 1'b0;
         end
      end
   end

   assign tx_last_fire = pkt_tx_TVALID && pkt_tx_TREADY && pkt_tx_TDATA[DATA_WIDTH];

   // Saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_drop_count    <= '0;
         stat_pkt_count     <= '0;
         stat_len_err_count <= '0;
      end else begin
         if (drop && (stat_drop_count != '1))
            stat_drop_count <= stat_drop_count + 32'd1;
         if (tx_last_fire && (stat_pkt_count != '1))
            stat_pkt_count <= stat_pkt_count + 32'd1;
         if (tx_last_fire && pkt_tx_TERR && (stat_len_err_count != '1))
            stat_len_err_count <= stat_len_err_count + 16'd1;
      end
   end
endmodule

// File: doc/pkt_receiver_gen.md
Name: pkt_receiver_gen

Overview:
Parametrised next-generation TCP RX front end between the TCP/IP stack notification/RX-data streams and the user kernel datapath.
- Filters notifications by a programmable length rule.
- Issues read-package requests for accepted notifications.
- Buffers payload beats.
- Re-attaches session metadata to every outgoing payload beat.
- Adds start-of-packet and beat-count error flags, plus drop/accept/error statistics.

Parameters:
DATA_WIDTH, 512, payload beat width in bits (multiple of 64).
FIFO_ADDR_BITS, 5, log2 depth of each internal FIFO (notif, payload, metadata).
MAX_LEN, 4096, largest accepted message length in bytes.
LEN_ALIGN_LOG2, 6, accepted lengths must be multiples of 2^LEN_ALIGN_LOG2 bytes.

Ports:
clk  in  1  clock
rst  in  1  reset
s_axis_notifications_TDATA  in  88  notification; [15:0] session, [31:16] length, [87:32] ip/port/flags
s_axis_notifications_TVALID  in  1  notification valid
s_axis_notifications_TREADY  out  1  notification FIFO not full
s_axis_rx_data_TDATA  in  DATA_WIDTH+1  {tlast, data}
s_axis_rx_data_TVALID  in  1  payload valid
s_axis_rx_data_TREADY  out  1  payload FIFO not full
m_axis_read_package_TDATA  out  32  {length, session} of the accepted notification
m_axis_read_package_TVALID  out  1  read request valid
m_axis_read_package_TREADY  in  1  read request ready
pkt_tx_TDATA  out  88+DATA_WIDTH+1  {metadata, tlast, data}
pkt_tx_TSOP  out  1  first beat of the packet
pkt_tx_TERR  out  1  beat-count/tlast mismatch
pkt_tx_TVALID  out  1  output beat valid
pkt_tx_TREADY  in  1  downstream ready
stat_drop_count  out  32  notifications discarded
stat_pkt_count  out  32  packets completed (tlast beat accepted downstream)
stat_len_err_count  out  16  packets completed with TERR

Behaviour:
Clock and reset:
- Single clock domain on clk.
- Synchronous active-high reset rst.
- Reset clears all FIFOs, the FSM (to IDLE), all counters and the output register.
- Reset outputs: pkt_tx_TVALID=0, pkt_tx_TDATA=0, TSOP=0, TERR=0, m_axis_read_package_TVALID=0, stats=0.
- Reset mid-packet discards partial state. No beat is emitted for the aborted packet.

Notification filter (combinational on notif FIFO head, len=[31:16]):
- accept = (len!=0) && (len<=MAX_LEN) && (len[LEN_ALIGN_LOG2-1:0]==0).
- Reject: pop the head in the same cycle. No read request. stat_drop_count +1.
- Accept: m_axis_read_package_TVALID = head valid && metadata FIFO not full.
  - Pop only when TVALID && TREADY. Metadata FIFO is written in that same cycle.
  - TDATA = head[31:0].
- Throughput: one notification per cycle, accepted or dropped.

Output FSM:
- IDLE: when the metadata FIFO is non-empty:
  - pop it into meta_r;
  - exp_beats = ceil(len / (DATA_WIDTH/8));
  - beat_cnt = 0;
  - go to STREAM.
- STREAM: a payload FIFO head moves into the output register when the register is empty or pkt_tx_TREADY=1. For that beat:
  - TSOP = (beat_cnt==0).
  - TDATA = {meta_r, head}.
  - TERR = (beat_cnt>=exp_beats) || (tlast && beat_cnt+1!=exp_beats).
  - beat_cnt increments.
  - On tlast return to IDLE. The next packet may load in the following cycle.
- Payload arriving before its metadata stays in the payload FIFO (backpressure); it is never emitted without metadata.

Output register:
- Valid holds until TREADY; data stays stable while TVALID && !TREADY.
- Latency: 1 cycle from FIFO head to pkt_tx_TVALID.
- Sustained throughput: 1 beat/cycle within a packet; 1 bubble cycle per packet boundary.

Statistics:
- Counters saturate at all-ones.
- stat_pkt_count and stat_len_err_count increment on the tlast beat handshake, the latter only if TERR.

Test Plan:
- Filter: notifications len=128 then len=0, 100, 8192 with READY=1 → one read request {128,sid}; stat_drop_count=3; only the first appears in the metadata path.
- Normal packet: len=128, DATA_WIDTH=512, 2 beats with tlast on beat 2 → 2 output beats: TSOP=1,0; TERR=0,0; metadata on both; stat_pkt_count=1.
- Short/long mismatch:
  - len=192, tlast on beat 2 → TERR=1 on beat 2.
  - len=64, 3 beats → TERR=0,1,1.
  - stat_len_err_count=2.
- Backpressure: pkt_tx_TREADY toggled 1010… over 4-beat packet → data stable while stalled, no beat lost or duplicated; payload FIFO fills to 32 and s_axis_rx_data_TREADY drops.
- Ordering: payload beats presented 5 cycles before the notification → no output until metadata arrives, then correct pairing.
- Reset mid-STREAM: rst for 1 cycle after beat 1 of 3 → all outputs 0, counters 0, next packet starts with TSOP=1.
